alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//   Parametrised, pipelined successor to the 4-bit ALU: WIDTH-bit operands, 4-bit opcode, status flags.
//   Valid/ready handshake on input and output, two-stage buffered pipeline, optional iterative multiply.
//   Sits between the operand/decode logic and the register writeback; stalls cleanly under backpressure.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (>=4)
//   SHW    $clog2(WIDTH)  shift-amount width (derived, localparam)
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   rst        in   1      asynchronous, active-low reset (asserted when 0)
//   in_valid   in   1      operand/opcode present
//   in_ready   out  1      block can accept this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   op         in   4      opcode (alu_pkg::op_e)
//   out_valid  out  1      result present
//   out_ready  in   1      consumer accepts result
//   result     out  WIDTH  result
//   flags      out  4      {ovf, neg, zero, carry}
//   err        out  1      illegal opcode for this result
// BEHAVIOUR
//   Reset: out_valid=0, result=0, flags=0, err=0, both stages empty, mul FSM IDLE; in_ready=1 once rst=1.
//   Transfer: input on in_valid&&in_ready; output on out_valid&&out_ready. No drop, no duplicate, order kept.
//   Pipeline: S1 holds the captured op; S2 holds the computed result/flags. Each stage loads when empty or draining.
//   in_ready = !S1_full || S1 advancing; purely combinational from state and out_ready, never from in_valid.
//   Latency: single-cycle ops give out_valid 2 cycles after acceptance. Throughput is 1/cycle with out_ready=1.
//   Backpressure: with out_ready=0, at most 2 results are held and in_ready drops; outputs stay stable while held.
//   Ops: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 NOT a, 5 XOR, 6 SHL a<<b[SHW-1:0], 7 SHR logical, 8 MUL.
//   Ops 9-15: result=0, flags=0, err=1, normal latency.
//   carry: ADD carry-out; SUB borrow (a<b unsigned); MUL = any nonzero upper product bit; 0 for logic/shift ops.
//   ovf: signed overflow, ADD/SUB only, else 0. zero = (result==0). neg = result[WIDTH-1].
//   Arithmetic wraps modulo 2^WIDTH. Opcode decoding ignores b for NOT.
//   Reset mid-operation: everything in flight is discarded and out_valid drops asynchronously.
// CONFIGURATION
//   ALU_MUL_EN defined: op 8 runs a shift-add FSM in S1 (IDLE->MUL for WIDTH cycles->DONE->IDLE).
//     While the FSM is busy: S1 blocks, in_ready=0, and S2 may still drain.
//     Latency is WIDTH+2 cycles from acceptance to out_valid. result = low WIDTH bits of the product.
//   ALU_MUL_EN undefined: op 8 is illegal (err=1, result=0), no FSM hardware, all ops single-cycle.
// STRUCTURE
//   alu_pkg: op_e enum (4-bit), flag bit indices FLG_C/FLG_Z/FLG_N/FLG_V, mul_state_e {IDLE,MUL,DONE}.
//   Sub-module alu_core: combinational datapath (a,b,op) -> (result,flags,err), instanced in S1->S2 path.
//   alu_pipe owns the handshake, stage registers and the multiply FSM.
// TESTING (WIDTH=8)
//   ADD 0x0F+0x01 -> 0x10, flags 0, out_valid 2 cycles later.
//     ADD 0xFF+0x01 -> 0x00, carry=1, zero=1, ovf=0.
//   SUB 0x01-0x02 -> 0xFF, carry=1, neg=1.
//     SUB 0x80-0x01 -> 0x7F, ovf=1.
//   Logic/shift: AND 0xCA&0xAC -> 0x88; XOR -> 0x66; NOT 0x55 -> 0xAA; SHL 0x81,b=1 -> 0x02; op 12 -> err=1.
//   Backpressure: out_ready=0, issue 3 ops -> 2 accepted, in_ready=0.
//     Then out_ready=1 -> results in issue order, third op accepted next cycle.
//   MUL (ALU_MUL_EN): 0x0C*0x0B -> 0x84, carry=0, out_valid at cycle 10; in_ready=0 during cycles 1-8.
//     MUL 0x10*0x10 -> 0x00, carry=1, zero=1.
//   Reset: drive rst=0 mid-MUL with S2 full -> out_valid=0 immediately.
//     After rst=1: in_ready=1, next ADD 0x03+0x05 -> 0x08.

Source files
------------

// File: rtl/alu_pkg.sv
//==============================================================================
// Module   : alu_pkg
// Purpose  : Opcode, flag-index and multiply-state definitions shared by the ALU pipeline.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_NOT = 4'd4,
    OP_XOR = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_MUL = 4'd8
  } op_e;

  // Bit positions inside the {ovf, neg, zero, carry} flag vector
  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
//==============================================================================
// Module   : alu_core
// Purpose  : Combinational single-cycle ALU datapath (a, b, op) -> (result, flags, err).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = a - b;

  always_comb begin
    result = '0;
    flags  = '0;
    err    = 1'b0;
    case (op)
      OP_ADD: begin
        result       = w_sum[WIDTH-1:0];
        flags[FLG_C] = w_sum[WIDTH];
        flags[FLG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result       = w_diff;
        flags[FLG_C] = (a < b);
        flags[FLG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_NOT: result = ~a;
      OP_XOR: result = a ^ b;
      OP_SHL: result = a << b[SHW-1:0];
      OP_SHR: result = a >> b[SHW-1:0];
      // Multiply is not single-cycle; the pipeline substitutes its own product when enabled
      default: err = 1'b1;
    endcase
    if (!err) begin
      flags[FLG_Z] = (result == '0);
      flags[FLG_N] = result[WIDTH-1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
//==============================================================================
// Module   : alu_pipe
// Purpose  : Two-stage valid/ready ALU pipeline; optional shift-add multiply when ALU_MUL_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  logic             r_s1_full;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [3:0]       r_s1_op;

  logic             r_s2_full;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_err;

  logic [WIDTH-1:0] w_core_result;
  logic [3:0]       w_core_flags;
  logic             w_core_err;

  logic [WIDTH-1:0] w_s1_result;
  logic [3:0]       w_s1_flags;
  logic             w_s1_err;

  logic w_s1_done;
  logic w_s2_free;
  logic w_s1_adv;
  logic w_in_fire;

  assign w_s2_free = !r_s2_full || out_ready;
  assign w_s1_adv  = r_s1_full && w_s1_done && w_s2_free;
  assign in_ready  = !r_s1_full || w_s1_adv;
  assign w_in_fire = in_valid && in_ready;

  assign out_valid = r_s2_full;
  assign result    = r_result;
  assign flags     = r_flags;
  assign err       = r_err;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (r_s1_a),
    .b      (r_s1_b),
    .op     (r_s1_op),
    .result (w_core_result),
    .flags  (w_core_flags),
    .err    (w_core_err)
  );

`ifdef ALU_MUL_EN
  mul_state_e         r_mstate;
  logic [SHW-1:0]     r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic               w_in_mul;

  assign w_in_mul = w_in_fire && (op == OP_MUL);

  // A multiply starts the same edge it is captured into S1, so it never sits in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mstate <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      case (r_mstate)
        MUL: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == SHW'(WIDTH - 1)) begin
            r_mstate <= DONE;
          end
        end
        DONE: begin
          if (w_s1_adv) begin
            r_mstate <= IDLE;
          end
        end
        default: ;
      endcase
      if (w_in_mul) begin
        r_mstate <= MUL;
        r_cnt    <= '0;
        r_acc    <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, a};
        r_mplier <= b;
      end
    end
  end

  assign w_s1_done = (r_s1_op != OP_MUL) || (r_mstate == DONE);

  always_comb begin
    w_s1_result = w_core_result;
    w_s1_flags  = w_core_flags;
    w_s1_err    = w_core_err;
    if (r_s1_op == OP_MUL) begin
      w_s1_result        = r_acc[WIDTH-1:0];
      w_s1_flags         = '0;
      w_s1_flags[FLG_C]  = |r_acc[2*WIDTH-1:WIDTH];
      w_s1_flags[FLG_Z]  = (r_acc[WIDTH-1:0] == '0);
      w_s1_flags[FLG_N]  = r_acc[WIDTH-1];
      w_s1_err           = 1'b0;
    end
  end
`else
  assign w_s1_done   = 1'b1;
  assign w_s1_result = w_core_result;
  assign w_s1_flags  = w_core_flags;
  assign w_s1_err    = w_core_err;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_full <= 1'b0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_s1_op   <= '0;
    end else if (w_in_fire) begin
      r_s1_full <= 1'b1;
      r_s1_a    <= a;
      r_s1_b    <= b;
      r_s1_op   <= op;
    end else if (w_s1_adv) begin
      r_s1_full <= 1'b0;
    end
  end

  // S2 data is only rewritten on a load, so a held result stays stable under backpressure
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_full <= 1'b0;
      r_result  <= '0;
      r_flags   <= '0;
      r_err     <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_full <= 1'b1;
      r_result  <= w_s1_result;
      r_flags   <= w_s1_flags;
      r_err     <= w_s1_err;
    end else if (out_ready) begin
      r_s2_full <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
//==============================================================================
// Module   : tb_alu_pipe
// Purpose  : Self-checking bench for alu_pipe (WIDTH=8); honours ALU_MUL_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_pipe;

  typedef struct packed {
    logic [7:0] r;
    logic [3:0] f;
    logic       e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] flags;
  logic       err;

  int   total = 0;
  int   bad   = 0;
  logic got_in;
  exp_t q[$];

  alu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference: flags are {ovf, neg, zero, carry}, derived from integer arithmetic
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic [3:0] o);
    exp_t e;
    int   ua, ub, sa, sb, full;
    logic c, v, legal;
    ua = int'(x); ub = int'(y);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    c = 1'b0; v = 1'b0; legal = 1'b1; full = 0;
    case (o)
      4'd0: begin full = ua + ub; c = (full > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      4'd1: begin full = ua - ub; c = (ua < ub);    v = (sa - sb > 127) || (sa - sb < -128); end
      4'd2: full = ua & ub;
      4'd3: full = ua | ub;
      4'd4: full = 255 - ua;
      4'd5: full = ua ^ ub;
      4'd6: full = ua * (2 ** (ub % 8));
      4'd7: full = ua / (2 ** (ub % 8));
`ifdef ALU_MUL_EN
      4'd8: begin full = ua * ub; c = (full > 255); end
`endif
      default: legal = 1'b0;
    endcase
    if (legal) begin
      e.r = 8'(full & 255);
      e.f = {v, (e.r >= 8'd128), (e.r == 8'd0), c};
      e.e = 1'b0;
    end else begin
      e.r = 8'd0;
      e.f = 4'd0;
      e.e = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // Observe handshakes mid-cycle, then advance to just after the next rising edge
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst && in_valid && in_ready) begin
      q.push_back(model(a, b, op));
      got_in = 1'b1;
    end
    if (rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("sb_underflow", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("sb_result", 32'(result), 32'(e.r));
        chk("sb_flags",  32'(flags),  32'(e.f));
        chk("sb_err",    32'(err),    32'(e.e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic [3:0] o);
    a = x; b = y; op = o; in_valid = 1'b1; got_in = 1'b0;
    for (int k = 0; k < 60 && !got_in; k++) tick();
    chk("issue_accept", 32'(got_in), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [7:0] x, input logic [7:0] y, input logic [3:0] o,
                       input logic [7:0] er, input logic [3:0] ef, input logic ee);
    out_ready = 1'b1;
    issue(x, y, o);
    for (int k = 0; k < 40 && !out_valid; k++) tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_res"},   32'(result),    32'(er));
    chk({tag, "_flags"}, 32'(flags),     32'(ef));
    chk({tag, "_err"},   32'(err),       32'(ee));
    tick();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int k = 0; k < 200 && (q.size() != 0 || out_valid); k++) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int         irdy_bad;
    int         first;
    logic [7:0] fr;
    logic [3:0] ff;
    logic [3:0] op2;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0; got_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_res",   32'(result),    32'd0);
    chk("rst_flags", 32'(flags),     32'd0);
    chk("rst_err",   32'(err),       32'd0);
    rst = 1'b1;
    #1;
    chk("rst_irdy", 32'(in_ready), 32'd1);

    // Two-cycle latency for a single-cycle op
    issue(8'h0F, 8'h01, 4'd0);
    chk("lat_c1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat_c2_valid", 32'(out_valid), 32'd1);
    chk("lat_c2_res",   32'(result),    32'h10);
    chk("lat_c2_flags", 32'(flags),     32'd0);
    tick();

    do_op("add_wrap", 8'hFF, 8'h01, 4'd0,  8'h00, 4'b0011, 1'b0);
    do_op("sub_brw",  8'h01, 8'h02, 4'd1,  8'hFF, 4'b0101, 1'b0);
    do_op("sub_ovf",  8'h80, 8'h01, 4'd1,  8'h7F, 4'b1000, 1'b0);
    do_op("and",      8'hCA, 8'hAC, 4'd2,  8'h88, 4'b0100, 1'b0);
    do_op("xor",      8'hCA, 8'hAC, 4'd5,  8'h66, 4'b0000, 1'b0);
    do_op("not",      8'h55, 8'h3C, 4'd4,  8'hAA, 4'b0100, 1'b0);
    do_op("shl",      8'h81, 8'h01, 4'd6,  8'h02, 4'b0000, 1'b0);
    do_op("shr",      8'h81, 8'h07, 4'd7,  8'h01, 4'b0000, 1'b0);
    do_op("illegal",  8'h12, 8'h34, 4'd12, 8'h00, 4'b0000, 1'b1);

    // Backpressure: two results held, third op stalls until the consumer drains
    out_ready = 1'b0;
    #1;
    a = 8'd1; b = 8'd1; op = 4'd0; in_valid = 1'b1; got_in = 1'b0;
    tick();
    chk("bp_acc1", 32'(got_in), 32'd1);
    a = 8'd2; b = 8'd2; got_in = 1'b0;
    tick();
    chk("bp_acc2", 32'(got_in), 32'd1);
    a = 8'd3; b = 8'd3; got_in = 1'b0;
    chk("bp_irdy_low", 32'(in_ready), 32'd0);
    tick();
    chk("bp_hold_acc",   32'(got_in),    32'd0);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_res",   32'(result),    32'd2);
    tick();
    chk("bp_stable_res", 32'(result), 32'd2);
    out_ready = 1'b1;
    #1;
    chk("bp_irdy_release", 32'(in_ready), 32'd1);
    tick();
    chk("bp_acc3", 32'(got_in), 32'd1);
    in_valid = 1'b0;
    drain();

`ifdef ALU_MUL_EN
    out_ready = 1'b1;
    issue(8'h0C, 8'h0B, 4'd8);
    irdy_bad = 0; first = 0; fr = '0; ff = '0;
    for (int n = 1; n <= 14; n++) begin
      if (n <= 8 && in_ready !== 1'b0) irdy_bad++;
      if (out_valid && first == 0) begin
        first = n; fr = result; ff = flags;
      end
      tick();
    end
    chk("mul_irdy_busy", 32'(irdy_bad), 32'd0);
    chk("mul_latency",   32'(first),    32'd10);
    chk("mul_res",       32'(fr),       32'h84);
    chk("mul_flags",     32'(ff),       32'b0100);
    do_op("mul_wrap", 8'h10, 8'h10, 4'd8, 8'h00, 4'b0011, 1'b0);
    op2 = 4'd8;
`else
    do_op("mul_off", 8'h03, 8'h04, 4'd8, 8'h00, 4'b0000, 1'b1);
    op2 = 4'd0;
`endif

    // Reset with S2 full and S1 occupied
    out_ready = 1'b0;
    issue(8'h01, 8'h02, 4'd0);
    issue(8'h03, 8'h03, op2);
    tick();
    tick();
    chk("prerst_valid", 32'(out_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_res",   32'(result),    32'd0);
    q.delete();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("postrst_irdy",  32'(in_ready),  32'd1);
    chk("postrst_valid", 32'(out_valid), 32'd0);
    do_op("postrst_add", 8'h03, 8'h05, 4'd0, 8'h08, 4'b0000, 1'b0);

    // Random traffic with random backpressure against the reference model
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      a         = 8'($urandom);
      b         = 8'($urandom);
      op        = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
